qam_rx_decimator: RTL and testbench
===================================

# qam_rx_decimator

Receive-side counterpart of the upsampling/filtering modulator. The block accepts the stream of signed 10-bit I/Q samples at the upsampled rate and runs a rectangular matched filter (integrate-and-dump) over each symbol period. It decimates to one decision per symbol, slices each rail to a 16-QAM level and emits the recovered 4-bit symbol. It sits between the channel/loopback sample path and the bit sink, and also exposes a 12-bit readback word for the control interface.

## Interface
- `UPS`, 4: samples per symbol (decimation factor); power of two, 2..256
- `AMP`, 64: unit level amplitude; transmitter levels are ±AMP and ±3·AMP
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  reset; asynchronous, active-low (`rst`=0 resets)
- `in_valid`  input  1  I_in/Q_in carry a sample this cycle
- `sync`  input  1  qualified by in_valid; marks that sample as phase 0 of a symbol
- `I_in`  input  10  signed in-phase sample
- `Q_in`  input  10  signed quadrature sample
- `data_out`  output  4  recovered symbol: [3:2] I decision, [1:0] Q decision
- `out_valid`  output  1  one-cycle strobe, data_out new
- `sym_count`  output  12  symbols emitted since reset, wraps 4095→0
- `spi_data_out`  output  12  readback: {state, overrun, 2'b00, last data_out, 4'b0000}; bit 11 = state

## Operation
- Gray mapping per rail (bits→level): 00→−3A, 01→−A, 11→+A, 10→+3A.
- Accumulator width ACC_W = 10 + log2(UPS), signed, sign-extended adds; cannot overflow.
- States: IDLE, RUN.
  - IDLE: ignore samples until in_valid&&sync; that sample loads acc_I/acc_Q (not added), phase=1, → RUN.
  - RUN: each in_valid sample added to acc_I/acc_Q, phase++. On the UPS-th sample (phase==UPS−1 at accept) the sum including that sample is sliced, out_valid pulses, sym_count++, and the accumulators restart at 0, phase=0 (next sample is phase 0).
  - in_valid&&sync in RUN at phase≠0: partial accumulation discarded, sample loaded as phase 0, overrun=1 (sticky until reset). sync at phase 0 is normal.
- Slicer per rail, T = 2·AMP·UPS: acc ≥ T→10; 0 ≤ acc < T→11; −T ≤ acc < 0→01; acc < −T→00. Exactly 0 decides 11, exactly T decides 10.
- in_valid low: nothing advances; gaps of any length allowed mid-symbol.

## Timing
- Reset values: data_out=0, out_valid=0, sym_count=0, spi_data_out=0, state=IDLE, accumulators 0, phase 0, overrun 0.
- Latency: out_valid and data_out valid the cycle after the clock edge accepting the last sample of the symbol (one registered stage). data_out holds until next decision.
- Back-to-back: with in_valid constant high, out_valid pulses every UPS cycles.
- Reset asserted mid-symbol: all state cleared asynchronously; first decision after release requires a new sync.
- sync without in_valid has no effect.

## Structure
- Package `qam_rx_pkg`: state enum (IDLE, RUN), Gray level encodings, slicer function or threshold constant builder.
- One sub-module `qam_slicer`: combinational, parameter ACC_W/AMP/UPS, inputs acc_I/acc_Q, output 4-bit decision. Top holds FSM, phase counter, accumulators, output registers.

## Test plan
- UPS=4, AMP=64: sync on first, 4 samples I=192, Q=−64, in_valid high → one out_valid, data_out=4'b1001, sym_count=1.
- Four consecutive symbols (I,Q)=(−192,−192),(−64,64),(64,192),(192,−192) continuous → data_out 0000,0111,1110,1000 at strobes 4 cycles apart, sym_count=4.
- Same first symbol with in_valid low for 3 cycles between samples 2 and 3 → identical decision 1001, strobe delayed by 3 cycles.
- Threshold edges: sums I=512 (T) and I=0 → I decision 10 and 11; I=−512 → 01, I=−516 → 00.
- sync reasserted at phase 2 → no strobe for aborted symbol, overrun bit (spi_data_out[10]) =1, next full symbol decoded correctly.
- rst low mid-symbol after 2 samples → all outputs 0 immediately; samples without sync after release produce no out_valid.

Source files
------------

// File: rtl/qam_rx_pkg.sv
// qam_rx_pkg: shared types, Gray level codes and slicer helpers for the QAM receive decimator.
package qam_rx_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [1:0] LVL_N3 = 2'b00;
    localparam logic [1:0] LVL_N1 = 2'b01;
    localparam logic [1:0] LVL_P1 = 2'b11;
    localparam logic [1:0] LVL_P3 = 2'b10;

    // Decision boundary between the A and 3A levels after integrating UPS samples
    function automatic int slice_thresh(input int amp, input int ups);
        return 2 * amp * ups;
    endfunction

    function automatic logic [1:0] slice_rail(input int acc, input int t);
        return acc >= t ? LVL_P3 : acc >= 0 ? LVL_P1 : acc >= -t ? LVL_N1 : LVL_N3;
    endfunction

endpackage

// File: rtl/qam_slicer.sv
// qam_slicer: maps integrated I/Q sums to a 4-bit Gray-coded 16-QAM decision.
module qam_slicer
    import qam_rx_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int AMP   = 64,
    parameter int UPS   = 4
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [ACC_W-1:0] acc_q,
    output logic        [3:0]       decision
);

    localparam int T = slice_thresh(AMP, UPS);

    always_comb decision = {slice_rail(int'(acc_i), T), slice_rail(int'(acc_q), T)};

endmodule

// File: rtl/qam_rx_decimator.sv
// qam_rx_decimator: integrate-and-dump matched filter, decimation by UPS and 16-QAM slicing.
module qam_rx_decimator
    import qam_rx_pkg::*;
#(
    parameter int UPS = 4,
    parameter int AMP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        sync,
    input  logic [9:0]  I_in,
    input  logic [9:0]  Q_in,
    output logic [3:0]  data_out,
    output logic        out_valid,
    output logic [11:0] sym_count,
    output logic [11:0] spi_data_out
);

    localparam int PW    = $clog2(UPS);
    localparam int ACC_W = 10 + PW;

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc_i, acc_q, acc_i_nx, acc_q_nx;
    logic signed [ACC_W-1:0] smp_i, smp_q, sum_i, sum_q;
    logic        [PW-1:0]    phase, phase_nx;
    logic                    overrun, overrun_nx;
    logic                    last, dump;
    logic        [3:0]       decision;

    always_comb begin
        smp_i      = {{PW{I_in[9]}}, I_in};
        smp_q      = {{PW{Q_in[9]}}, Q_in};
        sum_i      = acc_i + smp_i;
        sum_q      = acc_q + smp_q;
        last       = phase == PW'(UPS - 1);
        state_nx   = state;
        acc_i_nx   = acc_i;
        acc_q_nx   = acc_q;
        phase_nx   = phase;
        overrun_nx = overrun;
        dump       = 1'b0;
        // A sync at phase 0 loads into an empty accumulator, so only a mid-symbol sync is an overrun
        if (in_valid && sync) begin
            state_nx   = RUN;
            acc_i_nx   = smp_i;
            acc_q_nx   = smp_q;
            phase_nx   = PW'(1);
            overrun_nx = overrun || (state == RUN && phase != '0);
        end else if (in_valid && state == RUN) begin
            dump     = last;
            acc_i_nx = last ? '0 : sum_i;
            acc_q_nx = last ? '0 : sum_q;
            phase_nx = phase + 1'b1;
        end
    end

    qam_slicer #(.ACC_W(ACC_W), .AMP(AMP), .UPS(UPS)) u_slicer (
        .acc_i    (sum_i),
        .acc_q    (sum_q),
        .decision (decision)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc_i     <= '0;
            acc_q     <= '0;
            phase     <= '0;
            overrun   <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            sym_count <= '0;
        end else begin
            state     <= state_nx;
            acc_i     <= acc_i_nx;
            acc_q     <= acc_q_nx;
            phase     <= phase_nx;
            overrun   <= overrun_nx;
            out_valid <= dump;
            if (dump) begin
                data_out  <= decision;
                sym_count <= sym_count + 1'b1;
            end
        end
    end

    assign spi_data_out = {state == RUN, overrun, 2'b00, data_out, 4'b0000};

endmodule

// File: tb/tb_qam_rx_decimator.sv
// tb_qam_rx_decimator: directed and randomized checks against a queue-based symbol model.
module tb_qam_rx_decimator;

    localparam int UPS = 4;
    localparam int AMP = 64;
    localparam int T   = 2 * AMP * UPS;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, sync;
    logic [9:0]  I_in, Q_in;
    logic [3:0]  data_out;
    logic        out_valid;
    logic [11:0] sym_count, spi_data_out;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit          m_run, m_ovr, m_valid;
    logic [3:0]  m_data;
    logic [11:0] m_cnt;
    int          qi[$], qq[$];

    qam_rx_decimator #(.UPS(UPS), .AMP(AMP)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .sync         (sync),
        .I_in         (I_in),
        .Q_in         (Q_in),
        .data_out     (data_out),
        .out_valid    (out_valid),
        .sym_count    (sym_count),
        .spi_data_out (spi_data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rail(input int s);
        if (s >= T) return 2'b10;
        if (s >= 0) return 2'b11;
        if (s >= -T) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_run = 0; m_ovr = 0; m_valid = 0; m_data = '0; m_cnt = '0;
        qi.delete(); qq.delete();
    endtask

    task automatic model_accept(input bit v, input bit s, input int i, input int q);
        int si, sq;
        m_valid = 0;
        if (!v) return;
        if (s) begin
            if (m_run && qi.size() != 0) m_ovr = 1;
            qi.delete(); qq.delete();
            qi.push_back(i); qq.push_back(q);
            m_run = 1;
        end else if (m_run) begin
            qi.push_back(i); qq.push_back(q);
            if (qi.size() == UPS) begin
                si = 0; sq = 0;
                foreach (qi[k]) begin si += qi[k]; sq += qq[k]; end
                m_data  = {rail(si), rail(sq)};
                m_valid = 1;
                m_cnt   = m_cnt + 12'd1;
                qi.delete(); qq.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 12'(out_valid), 12'(m_valid));
        chk({tag, ".data"},  12'(data_out), 12'(m_data));
        chk({tag, ".count"}, sym_count, m_cnt);
        chk({tag, ".spi"},   spi_data_out, {m_run, m_ovr, 2'b00, m_data, 4'b0000});
    endtask

    task automatic step(input bit v, input bit s, input int i, input int q);
        in_valid = v; sync = s; I_in = 10'(i); Q_in = 10'(q);
        @(posedge clk);
        cyc++;
        model_accept(v, s, i, q);
        #1 check_all("cyc");
    endtask

    task automatic send_sym(input int i, input int q, input int gap);
        for (int k = 0; k < UPS; k++) begin
            if (k == 2) for (int g = 0; g < gap; g++) step(0, 0, 0, 0);
            step(1, k == 0, i, q);
        end
    endtask

    initial begin
        int c0, li, lq, len;
        int lv[4] = '{-192, -64, 64, 192};
        rst = 1'b1; in_valid = 0; sync = 0; I_in = '0; Q_in = '0;
        model_reset();
        #2 rst = 1'b0;
        #2 check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        send_sym(192, -64, 0);
        chk("tp1.valid", 12'(out_valid), 12'd1);
        chk("tp1.data", 12'(data_out), 12'b1001);
        chk("tp1.count", sym_count, 12'd1);

        send_sym(-192, -192, 0); chk("b2b0", 12'(data_out), 12'b0000);
        send_sym(-64, 64, 0);    chk("b2b1", 12'(data_out), 12'b0111);
        send_sym(64, 192, 0);    chk("b2b2", 12'(data_out), 12'b1110);
        send_sym(192, -192, 0);  chk("b2b3", 12'(data_out), 12'b1000);
        chk("b2b.count", sym_count, 12'd5);

        step(0, 0, 0, 0);
        c0 = cyc;
        send_sym(192, -64, 3);
        chk("gap.data", 12'(data_out), 12'b1001);
        chk("gap.latency", 12'(cyc - c0), 12'(UPS + 3));
        chk("gap.valid", 12'(out_valid), 12'd1);

        send_sym(128, 64, 0);    chk("thr.T", 12'(data_out), 12'b1011);
        send_sym(0, 0, 0);       chk("thr.zero", 12'(data_out), 12'b1111);
        send_sym(-128, -128, 0); chk("thr.negT", 12'(data_out), 12'b0101);
        send_sym(-129, 64, 0);   chk("thr.below", 12'(data_out), 12'b0011);

        step(1, 1, 192, -64);
        step(1, 0, 192, -64);
        step(1, 1, 192, -64);
        chk("ovr.bit", 12'(spi_data_out[10]), 12'd1);
        for (int k = 1; k < UPS; k++) step(1, 0, 192, -64);
        chk("ovr.data", 12'(data_out), 12'b1001);
        chk("ovr.valid", 12'(out_valid), 12'd1);

        step(1, 1, 64, 64);
        step(1, 0, 64, 64);
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("rst_async");
        chk("rst.spi", spi_data_out, 12'd0);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 2 * UPS; k++) step(1, 0, 192, 192);
        chk("rst.nosync", sym_count, 12'd0);

        for (int k = 0; k < 300; k++)
            step($urandom_range(3) != 0, $urandom_range(9) == 0,
                 int'($urandom_range(1023)) - 512, int'($urandom_range(1023)) - 512);

        for (int n = 0; n < 4300; n++) begin
            li  = lv[$urandom_range(3)];
            lq  = lv[$urandom_range(3)];
            len = ($urandom_range(49) == 0) ? int'($urandom_range(1, UPS - 1)) : UPS;
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(7) == 0)
                    step(0, $urandom_range(1) == 1, int'($urandom_range(1023)), int'($urandom_range(1023)));
                step(1, k == 0, li + int'($urandom_range(80)) - 40, lq + int'($urandom_range(80)) - 40);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
